l1_inst_cache_hitrate_monitor: RTL and testbench
================================================

Name: l1_inst_cache_hitrate_monitor

Overview:
- Consumes the 7-bit rolling hit count (hits in the last 100 valid L1 instruction-cache lookups) from the L1I hit counter, together with the same lookup-valid strobe.
- Samples the count periodically and keeps last/min/max statistics.
- Drives a low-hit-rate alarm with hysteresis, plus a sticky interrupt.
- Exposes the statistics through a one-cycle-latency read port toward the core's status registers.

Parameters:
- SAMPLE_PERIOD, 100, number of valid lookups between samples (range 1..65535).
- LOW_TH, 70, alarm sets when a sample is < LOW_TH.
- HIGH_TH, 85, alarm clears when a sample is >= HIGH_TH; must be >= LOW_TH.

Ports:
- iCLOCK  in  1  clock.
- iRESET  in  1  asynchronous active-high reset.
- iCACHE_VALID  in  1  lookup-valid strobe; same signal that feeds the hit counter.
- iINFO_COUNT  in  7  rolling hit count, 0..100, from the hit counter.
- iCLEAR  in  1  one-cycle statistics clear.
- iIRQ_ACK  in  1  clears oIRQ.
- iRD_REQ  in  1  read request.
- iRD_SEL  in  2  read select.
- oRD_VALID  out  1  read data valid.
- oRD_DATA  out  32  read data.
- oWINDOW_VALID  out  1  high once the 100-entry window is full and the count is meaningful.
- oLOW_HITRATE  out  1  alarm level.
- oIRQ  out  1  sticky interrupt.

Behaviour:
- Reset values (all asserted asynchronously on iRESET):
  - Outputs: oRD_VALID=0, oRD_DATA=0, oWINDOW_VALID=0, oLOW_HITRATE=0, oIRQ=0.
  - Internal: last=0, min=7'h7F, max=0, nsamp=0, fill counter=0, period counter=0, delay pipe=0.
- Lag rule: the counter output lags its window by 3 cycles. A lookup accepted at cycle t is reflected in iINFO_COUNT from cycle t+3.
- FSM state WARMUP:
  - Each cycle with iCACHE_VALID increments a 7-bit fill counter.
  - When the 100th valid is seen at cycle t, go to SETTLE.
- FSM state SETTLE:
  - Wait 3 cycles.
  - At t+3, enter MONITOR and set oWINDOW_VALID=1 from that cycle.
  - iCACHE_VALID during SETTLE advances the period counter.
- FSM state MONITOR:
  - MONITOR is terminal; only iRESET returns the FSM to WARMUP. iCLEAR does not.
  - A 16-bit period counter increments on iCACHE_VALID. Reaching SAMPLE_PERIOD-1 with iCACHE_VALID high raises a tick and wraps the counter to 0.
  - The tick enters a 3-stage delay pipe. When it emerges, the sample is iINFO_COUNT on that cycle.
- Sample update, on the cycle the tick emerges:
  - last <= sample.
  - min <= (sample < min) ? sample : min.
  - max <= (sample > max) ? sample : max.
  - nsamp <= nsamp saturating at 16'hFFFF.
- Alarm and interrupt:
  - Alarm sets if sample < LOW_TH. It clears if sample >= HIGH_TH. Otherwise it holds.
  - A 0->1 alarm transition sets oIRQ in the same cycle as oLOW_HITRATE rises.
  - oIRQ holds until a cycle with iIRQ_ACK=1 and no new set; a set in the same cycle as ack wins.
- Back-to-back ticks (SAMPLE_PERIOD=1 with continuous valids): every cycle produces a sample, and the pipe carries multiple ticks in flight.
- iCLEAR:
  - Resets last, min, max and nsamp to their reset values, flushes the delay pipe, and forces oLOW_HITRATE=0.
  - Does not touch oIRQ, the FSM or the period counter.
  - Clear beats a tick emerging in the same cycle; that sample is discarded.
- Read port:
  - iRD_REQ at cycle t produces oRD_VALID=1 at t+1 for exactly one cycle, with oRD_DATA registered from state at cycle t. Back-to-back requests are allowed.
  - iRD_SEL=0: {25'b0,last}. iRD_SEL=1: {25'b0,min}. iRD_SEL=2: {25'b0,max}.
  - iRD_SEL=3: {oIRQ, oLOW_HITRATE, oWINDOW_VALID, 13'b0, nsamp}.
  - oRD_DATA returns to 0 when oRD_VALID is 0.
- Input robustness: iINFO_COUNT >100 is not expected. No clamping is done; the value is used as-is.

Test Plan:
- Reset, then 99 valids -> oWINDOW_VALID=0. 100th valid at cycle t -> oWINDOW_VALID=1 at t+3; no sample before the first period completes.
- With the window valid, drive iINFO_COUNT=90, then 60, then 80, then 86 across four periods (SAMPLE_PERIOD=100) -> oLOW_HITRATE stays 0 through sample 1; rises on the 60 sample (oIRQ=1); stays 1 on 80; falls on 86. Reads give last=86, min=60, max=90, nsamp=4.
- oIRQ set, iIRQ_ACK pulsed in the same cycle as a new 0->1 alarm -> oIRQ remains 1. A later lone ack -> oIRQ=0 next cycle.
- iCLEAR asserted on the cycle a tick emerges -> sample discarded. Read sel3 gives nsamp=0 and alarm=0. Sel1 gives min=7'h7F; sel2 gives max=0.
- SAMPLE_PERIOD=1, continuous valids with iINFO_COUNT ramping 50..54 -> five consecutive samples and min=50, max=54. iRD_REQ on consecutive cycles returns valid data every cycle.
- Assert iRESET asynchronously mid-MONITOR with oIRQ=1 -> all outputs 0 immediately. After release, WARMUP requires 100 fresh valids.

Source files
------------

// File: rtl/l1_inst_cache_hitrate_monitor_if.sv
// ----------------------------------------------------------------------------
// l1_inst_cache_hitrate_monitor_if
//
// Purpose:
//   Groups the L1I hit-rate monitor's lookup inputs, control strobes, status
//   read port and alarm outputs into one bundle. Clock and reset stay outside
//   the interface as plain ports of the monitor.
//
// Signals:
//   iCACHE_VALID   lookup-valid strobe (same strobe that feeds the hit counter)
//   iINFO_COUNT    7-bit rolling hit count (0..100) from the hit counter
//   iCLEAR         one-cycle statistics clear
//   iIRQ_ACK       interrupt acknowledge
//   iRD_REQ        status read request
//   iRD_SEL        status read select
//   oRD_VALID      read data valid (one cycle after iRD_REQ)
//   oRD_DATA       read data, zero when oRD_VALID is low
//   oWINDOW_VALID  hit count window is full and meaningful
//   oLOW_HITRATE   low hit-rate alarm level
//   oIRQ           sticky interrupt
//
// Modports:
//   master  core / status-register side (drives inputs, observes outputs)
//   slave   the monitor itself
// ----------------------------------------------------------------------------
interface l1_inst_cache_hitrate_monitor_if;
    logic        iCACHE_VALID;
    logic [6:0]  iINFO_COUNT;
    logic        iCLEAR;
    logic        iIRQ_ACK;
    logic        iRD_REQ;
    logic [1:0]  iRD_SEL;
    logic        oRD_VALID;
    logic [31:0] oRD_DATA;
    logic        oWINDOW_VALID;
    logic        oLOW_HITRATE;
    logic        oIRQ;

    modport master (
        output iCACHE_VALID,
        output iINFO_COUNT,
        output iCLEAR,
        output iIRQ_ACK,
        output iRD_REQ,
        output iRD_SEL,
        input  oRD_VALID,
        input  oRD_DATA,
        input  oWINDOW_VALID,
        input  oLOW_HITRATE,
        input  oIRQ
    );

    modport slave (
        input  iCACHE_VALID,
        input  iINFO_COUNT,
        input  iCLEAR,
        input  iIRQ_ACK,
        input  iRD_REQ,
        input  iRD_SEL,
        output oRD_VALID,
        output oRD_DATA,
        output oWINDOW_VALID,
        output oLOW_HITRATE,
        output oIRQ
    );
endinterface

// File: rtl/l1_inst_cache_hitrate_monitor.sv
// ----------------------------------------------------------------------------
// l1_inst_cache_hitrate_monitor
//
// Purpose:
//   Watches the rolling L1 instruction-cache hit count (hits in the last 100
//   valid lookups). After the window has filled, the count is sampled once
//   every SAMPLE_PERIOD valid lookups and last/min/max/sample-count
//   statistics are kept. A low hit-rate alarm with hysteresis (set below
//   LOW_TH, cleared at or above HIGH_TH) drives a sticky interrupt. The
//   statistics are readable through a one-cycle-latency read port.
//
// Parameters:
//   SAMPLE_PERIOD  valid lookups between samples (1..65535)
//   LOW_TH         alarm sets when a sample is below this value
//   HIGH_TH        alarm clears when a sample is at or above this value
//
// Ports:
//   iCLOCK   clock
//   iRESET   asynchronous active-high reset
//   bus      slave side of l1_inst_cache_hitrate_monitor_if
//
// Read map (oRD_DATA):
//   sel 0  {25'b0, last}
//   sel 1  {25'b0, min}
//   sel 2  {25'b0, max}
//   sel 3  {oIRQ, oLOW_HITRATE, oWINDOW_VALID, 13'b0, nsamp}
// ----------------------------------------------------------------------------
module l1_inst_cache_hitrate_monitor #(
    parameter int unsigned SAMPLE_PERIOD = 100,
    parameter int unsigned LOW_TH        = 70,
    parameter int unsigned HIGH_TH       = 85
) (
    input  logic                          iCLOCK,
    input  logic                          iRESET,
    l1_inst_cache_hitrate_monitor_if.slave bus
);

    localparam logic [15:0] PERIOD_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [6:0]  LOW_C       = 7'(LOW_TH);
    localparam logic [6:0]  HIGH_C      = 7'(HIGH_TH);
    localparam logic [6:0]  FILL_LAST   = 7'd99;
    localparam logic [6:0]  MIN_INIT    = 7'h7F;

    typedef enum logic [1:0] {
        ST_WARMUP  = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [6:0]  fill_cnt_q;
    logic [1:0]  settle_cnt_q;
    logic [15:0] period_cnt_q;
    logic        period_wrap;
    logic        tick;
    logic [2:0]  pipe_q;
    logic        emerge;
    logic [6:0]  sample;

    logic [6:0]  last_q;
    logic [6:0]  min_q;
    logic [6:0]  max_q;
    logic [15:0] nsamp_q;
    logic        alarm_q;
    logic        alarm_d;
    logic        irq_q;
    logic        irq_set;
    logic        window_valid;

    logic        rd_valid_q;
    logic [31:0] rd_data_q;
    logic [31:0] rd_mux;

    // ------------------------------------------------------------------
    // Window fill / settle FSM
    // ------------------------------------------------------------------
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= ST_WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // SETTLE is occupied for two cycles so that MONITOR begins exactly three
    // cycles after the 100th valid, matching the hit counter's output lag.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WARMUP: begin
                if (bus.iCACHE_VALID && (fill_cnt_q == FILL_LAST)) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == 2'd1) begin
                    state_d = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                state_d = ST_MONITOR;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            fill_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            if ((state_q == ST_WARMUP) && bus.iCACHE_VALID) begin
                fill_cnt_q <= fill_cnt_q + 7'd1;
            end
            if (state_q == ST_SETTLE) begin
                settle_cnt_q <= settle_cnt_q + 2'd1;
            end else begin
                settle_cnt_q <= '0;
            end
        end
    end

    assign window_valid = (state_q == ST_MONITOR);

    // ------------------------------------------------------------------
    // Sample period counter and tick delay pipe
    // ------------------------------------------------------------------
    // The period counter already runs during SETTLE so that the first
    // period is measured from the end of the fill, but ticks only count
    // once the window is valid.
    assign period_wrap = bus.iCACHE_VALID && (period_cnt_q == PERIOD_LAST);
    assign tick        = window_valid && period_wrap;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            period_cnt_q <= '0;
        end else if ((state_q != ST_WARMUP) && bus.iCACHE_VALID) begin
            if (period_wrap) begin
                period_cnt_q <= '0;
            end else begin
                period_cnt_q <= period_cnt_q + 16'd1;
            end
        end
    end

    // The pipe matches the hit counter's three-cycle lag: the count seen when
    // a tick leaves the pipe covers the lookup that produced the tick.
    assign emerge = pipe_q[2];
    assign sample = bus.iINFO_COUNT;

    // ------------------------------------------------------------------
    // Statistics and alarm
    // ------------------------------------------------------------------
    always_comb begin
        alarm_d = alarm_q;
        if (sample < LOW_C) begin
            alarm_d = 1'b1;
        end else if (sample >= HIGH_C) begin
            alarm_d = 1'b0;
        end
    end

    assign irq_set = emerge && !bus.iCLEAR && !alarm_q && alarm_d;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            pipe_q  <= '0;
            last_q  <= '0;
            min_q   <= MIN_INIT;
            max_q   <= '0;
            nsamp_q <= '0;
            alarm_q <= 1'b0;
        end else if (bus.iCLEAR) begin
            // Clear wins over a tick leaving the pipe in the same cycle.
            pipe_q  <= '0;
            last_q  <= '0;
            min_q   <= MIN_INIT;
            max_q   <= '0;
            nsamp_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            pipe_q <= {pipe_q[1:0], tick};
            if (emerge) begin
                last_q <= sample;
                if (sample < min_q) begin
                    min_q <= sample;
                end
                if (sample > max_q) begin
                    max_q <= sample;
                end
                if (nsamp_q != '1) begin
                    nsamp_q <= nsamp_q + 16'd1;
                end
                alarm_q <= alarm_d;
            end
        end
    end

    // A new alarm edge beats an acknowledge arriving in the same cycle.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (bus.iIRQ_ACK) begin
            irq_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Status read port
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        unique case (bus.iRD_SEL)
            2'd0:    rd_mux = {25'b0, last_q};
            2'd1:    rd_mux = {25'b0, min_q};
            2'd2:    rd_mux = {25'b0, max_q};
            2'd3:    rd_mux = {irq_q, alarm_q, window_valid, 13'b0, nsamp_q};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.iRD_REQ;
            rd_data_q  <= bus.iRD_REQ ? rd_mux : '0;
        end
    end

    assign bus.oRD_VALID     = rd_valid_q;
    assign bus.oRD_DATA      = rd_data_q;
    assign bus.oWINDOW_VALID = window_valid;
    assign bus.oLOW_HITRATE  = alarm_q;
    assign bus.oIRQ          = irq_q;

endmodule

// File: tb/tb_l1_inst_cache_hitrate_monitor.sv
module tb_l1_inst_cache_hitrate_monitor;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned failures;

    l1_inst_cache_hitrate_monitor_if ifa ();
    l1_inst_cache_hitrate_monitor_if ifb ();

    // A: default sampling period; B: one sample per valid lookup.
    l1_inst_cache_hitrate_monitor #(
        .SAMPLE_PERIOD(100),
        .LOW_TH(70),
        .HIGH_TH(85)
    ) dut_a (
        .iCLOCK(clk),
        .iRESET(rst),
        .bus(ifa)
    );

    l1_inst_cache_hitrate_monitor #(
        .SAMPLE_PERIOD(1),
        .LOW_TH(70),
        .HIGH_TH(85)
    ) dut_b (
        .iCLOCK(clk),
        .iRESET(rst),
        .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input logic [1:0] sel, output logic v, output logic [31:0] d);
        ifa.iRD_REQ = 1'b1;
        ifa.iRD_SEL = sel;
        step();
        v = ifa.oRD_VALID;
        d = ifa.oRD_DATA;
        ifa.iRD_REQ = 1'b0;
    endtask

    task automatic read_b(input logic [1:0] sel, output logic v, output logic [31:0] d);
        ifb.iRD_REQ = 1'b1;
        ifb.iRD_SEL = sel;
        step();
        v = ifb.oRD_VALID;
        d = ifb.oRD_DATA;
        ifb.iRD_REQ = 1'b0;
    endtask

    // One full period on A holding the count, then the three lag cycles;
    // ack/clr are applied on the cycle the tick leaves the pipe.
    task automatic run_period_a(input logic [6:0] cnt, input logic ack, input logic clr);
        ifa.iINFO_COUNT  = cnt;
        ifa.iCACHE_VALID = 1'b1;
        repeat (100) step();
        ifa.iCACHE_VALID = 1'b0;
        step();
        step();
        ifa.iIRQ_ACK = ack;
        ifa.iCLEAR   = clr;
        step();
        ifa.iIRQ_ACK = 1'b0;
        ifa.iCLEAR   = 1'b0;
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] d;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (ifa.oRD_VALID !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", ifa.oRD_VALID); end
        checks++; if (ifa.oRD_DATA !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%08h exp=00000000", ifa.oRD_DATA); end
        checks++; if (ifa.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL reset_window got=%0b exp=0", ifa.oWINDOW_VALID); end
        checks++; if (ifa.oLOW_HITRATE !== 1'b0) begin failures++; $display("FAIL reset_low got=%0b exp=0", ifa.oLOW_HITRATE); end
        checks++; if (ifa.oIRQ !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", ifa.oIRQ); end
        read_a(2'd1, v, d);
        checks++; if (v !== 1'b1 || d !== 32'h0000_007F) begin failures++; $display("FAIL reset_min v=%0b got=%08h exp=0000007f", v, d); end
        read_a(2'd3, v, d);
        checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL reset_status v=%0b got=%08h exp=00000000", v, d); end
        step();
        checks++; if (ifa.oRD_VALID !== 1'b0 || ifa.oRD_DATA !== 32'h0) begin failures++; $display("FAIL rd_idle_zero v=%0b got=%08h exp=00000000", ifa.oRD_VALID, ifa.oRD_DATA); end
    endtask

    task automatic test_warmup();
        logic v;
        logic [31:0] d;
        // 99 valids with an idle cycle in between.
        ifa.iCACHE_VALID = 1'b1;
        ifb.iCACHE_VALID = 1'b1;
        repeat (50) step();
        ifa.iCACHE_VALID = 1'b0;
        ifb.iCACHE_VALID = 1'b0;
        step();
        ifa.iCACHE_VALID = 1'b1;
        ifb.iCACHE_VALID = 1'b1;
        repeat (49) step();
        ifa.iCACHE_VALID = 1'b0;
        ifb.iCACHE_VALID = 1'b0;
        step();
        checks++; if (ifa.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL warmup_99_a got=%0b exp=0", ifa.oWINDOW_VALID); end
        checks++; if (ifb.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL warmup_99_b got=%0b exp=0", ifb.oWINDOW_VALID); end
        // 100th valid at cycle t.
        ifa.iCACHE_VALID = 1'b1;
        ifb.iCACHE_VALID = 1'b1;
        step();
        ifa.iCACHE_VALID = 1'b0;
        ifb.iCACHE_VALID = 1'b0;
        checks++; if (ifa.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL window_t1 got=%0b exp=0", ifa.oWINDOW_VALID); end
        step();
        checks++; if (ifa.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL window_t2 got=%0b exp=0", ifa.oWINDOW_VALID); end
        step();
        checks++; if (ifa.oWINDOW_VALID !== 1'b1) begin failures++; $display("FAIL window_t3_a got=%0b exp=1", ifa.oWINDOW_VALID); end
        checks++; if (ifb.oWINDOW_VALID !== 1'b1) begin failures++; $display("FAIL window_t3_b got=%0b exp=1", ifb.oWINDOW_VALID); end
        read_a(2'd3, v, d);
        checks++; if (d !== 32'h2000_0000) begin failures++; $display("FAIL no_early_sample got=%08h exp=20000000", d); end
    endtask

    task automatic test_samples();
        logic v;
        logic [31:0] d;
        run_period_a(7'd90, 1'b0, 1'b0);
        checks++; if (ifa.oLOW_HITRATE !== 1'b0 || ifa.oIRQ !== 1'b0) begin failures++; $display("FAIL s90 low=%0b irq=%0b exp low=0 irq=0", ifa.oLOW_HITRATE, ifa.oIRQ); end
        run_period_a(7'd60, 1'b0, 1'b0);
        checks++; if (ifa.oLOW_HITRATE !== 1'b1 || ifa.oIRQ !== 1'b1) begin failures++; $display("FAIL s60 low=%0b irq=%0b exp low=1 irq=1", ifa.oLOW_HITRATE, ifa.oIRQ); end
        run_period_a(7'd80, 1'b0, 1'b0);
        checks++; if (ifa.oLOW_HITRATE !== 1'b1) begin failures++; $display("FAIL s80_hold low=%0b exp=1", ifa.oLOW_HITRATE); end
        run_period_a(7'd86, 1'b0, 1'b0);
        checks++; if (ifa.oLOW_HITRATE !== 1'b0 || ifa.oIRQ !== 1'b1) begin failures++; $display("FAIL s86 low=%0b irq=%0b exp low=0 irq=1", ifa.oLOW_HITRATE, ifa.oIRQ); end
        read_a(2'd0, v, d);
        checks++; if (v !== 1'b1 || d !== 32'd86) begin failures++; $display("FAIL stat_last v=%0b got=%0d exp=86", v, d); end
        read_a(2'd1, v, d);
        checks++; if (d !== 32'd60) begin failures++; $display("FAIL stat_min got=%0d exp=60", d); end
        read_a(2'd2, v, d);
        checks++; if (d !== 32'd90) begin failures++; $display("FAIL stat_max got=%0d exp=90", d); end
        read_a(2'd3, v, d);
        checks++; if (d !== 32'hA000_0004) begin failures++; $display("FAIL stat_status got=%08h exp=a0000004", d); end
    endtask

    task automatic test_irq_set_wins();
        logic v;
        logic [31:0] d;
        // Ack on the same cycle as the new 0->1 alarm edge.
        run_period_a(7'd50, 1'b1, 1'b0);
        checks++; if (ifa.oIRQ !== 1'b1 || ifa.oLOW_HITRATE !== 1'b1) begin failures++; $display("FAIL irq_set_wins irq=%0b low=%0b exp irq=1 low=1", ifa.oIRQ, ifa.oLOW_HITRATE); end
        read_a(2'd1, v, d);
        checks++; if (d !== 32'd50) begin failures++; $display("FAIL min_after_50 got=%0d exp=50", d); end
    endtask

    task automatic test_clear();
        logic v;
        logic [31:0] d;
        // A 40 sample would hold the alarm; the clear discards it instead.
        run_period_a(7'd40, 1'b0, 1'b1);
        checks++; if (ifa.oLOW_HITRATE !== 1'b0) begin failures++; $display("FAIL clear_low got=%0b exp=0", ifa.oLOW_HITRATE); end
        checks++; if (ifa.oIRQ !== 1'b1) begin failures++; $display("FAIL clear_keeps_irq got=%0b exp=1", ifa.oIRQ); end
        checks++; if (ifa.oWINDOW_VALID !== 1'b1) begin failures++; $display("FAIL clear_keeps_window got=%0b exp=1", ifa.oWINDOW_VALID); end
        read_a(2'd3, v, d);
        checks++; if (d !== 32'hA000_0000) begin failures++; $display("FAIL clear_status got=%08h exp=a0000000", d); end
        read_a(2'd1, v, d);
        checks++; if (d !== 32'h0000_007F) begin failures++; $display("FAIL clear_min got=%08h exp=0000007f", d); end
        read_a(2'd2, v, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_max got=%08h exp=00000000", d); end
        read_a(2'd0, v, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_last got=%08h exp=00000000", d); end
    endtask

    task automatic test_lone_ack_and_resume();
        logic v;
        logic [31:0] d;
        ifa.iIRQ_ACK = 1'b1;
        step();
        ifa.iIRQ_ACK = 1'b0;
        checks++; if (ifa.oIRQ !== 1'b0) begin failures++; $display("FAIL lone_ack irq=%0b exp=0", ifa.oIRQ); end
        // Period counter was untouched by the clear: the next period lines up.
        run_period_a(7'd75, 1'b0, 1'b0);
        checks++; if (ifa.oLOW_HITRATE !== 1'b0 || ifa.oIRQ !== 1'b0) begin failures++; $display("FAIL s75_hyst low=%0b irq=%0b exp low=0 irq=0", ifa.oLOW_HITRATE, ifa.oIRQ); end
        read_a(2'd3, v, d);
        checks++; if (d !== 32'h2000_0001) begin failures++; $display("FAIL resume_status got=%08h exp=20000001", d); end
        read_a(2'd1, v, d);
        checks++; if (d !== 32'd75) begin failures++; $display("FAIL resume_min got=%0d exp=75", d); end
        read_a(2'd2, v, d);
        checks++; if (d !== 32'd75) begin failures++; $display("FAIL resume_max got=%0d exp=75", d); end
    endtask

    task automatic test_back_to_back();
        logic v;
        logic [31:0] d;
        logic [31:0] exp_last;
        // Valids at cycles 0..4 give ticks leaving the pipe at cycles 3..7,
        // where the count ramps 50..54. A read every cycle returns last as
        // of the request cycle.
        for (int k = 0; k < 9; k++) begin
            ifb.iCACHE_VALID = (k < 5);
            ifb.iINFO_COUNT  = (k >= 3) ? 7'(50 + k - 3) : 7'd0;
            ifb.iRD_REQ      = 1'b1;
            ifb.iRD_SEL      = 2'd0;
            step();
            exp_last = (k >= 4) ? 32'(46 + k) : 32'd0;
            checks++; if (ifb.oRD_VALID !== 1'b1 || ifb.oRD_DATA !== exp_last) begin failures++; $display("FAIL b2b_last_%0d v=%0b got=%0d exp=%0d", k, ifb.oRD_VALID, ifb.oRD_DATA, exp_last); end
        end
        ifb.iRD_REQ      = 1'b0;
        ifb.iCACHE_VALID = 1'b0;
        read_b(2'd1, v, d);
        checks++; if (d !== 32'd50) begin failures++; $display("FAIL b2b_min got=%0d exp=50", d); end
        read_b(2'd2, v, d);
        checks++; if (d !== 32'd54) begin failures++; $display("FAIL b2b_max got=%0d exp=54", d); end
        read_b(2'd3, v, d);
        checks++; if (d !== 32'hE000_0005) begin failures++; $display("FAIL b2b_status got=%08h exp=e0000005", d); end
    endtask

    task automatic test_async_reset();
        ifb.iRD_REQ = 1'b1;
        ifb.iRD_SEL = 2'd3;
        step();
        ifb.iRD_REQ = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ifb.oIRQ !== 1'b0 || ifb.oLOW_HITRATE !== 1'b0 || ifb.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL async_reset_flags irq=%0b low=%0b win=%0b exp all 0", ifb.oIRQ, ifb.oLOW_HITRATE, ifb.oWINDOW_VALID); end
        checks++; if (ifb.oRD_VALID !== 1'b0 || ifb.oRD_DATA !== 32'h0) begin failures++; $display("FAIL async_reset_rd v=%0b got=%08h exp=0", ifb.oRD_VALID, ifb.oRD_DATA); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifb.iCACHE_VALID = 1'b1;
        repeat (99) step();
        ifb.iCACHE_VALID = 1'b0;
        step();
        checks++; if (ifb.oWINDOW_VALID !== 1'b0) begin failures++; $display("FAIL rewarm_99 got=%0b exp=0", ifb.oWINDOW_VALID); end
        ifb.iCACHE_VALID = 1'b1;
        step();
        ifb.iCACHE_VALID = 1'b0;
        step();
        step();
        checks++; if (ifb.oWINDOW_VALID !== 1'b1) begin failures++; $display("FAIL rewarm_100 got=%0b exp=1", ifb.oWINDOW_VALID); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ifa.iCACHE_VALID = 1'b0; ifa.iINFO_COUNT = 7'd0; ifa.iCLEAR = 1'b0;
        ifa.iIRQ_ACK = 1'b0; ifa.iRD_REQ = 1'b0; ifa.iRD_SEL = 2'd0;
        ifb.iCACHE_VALID = 1'b0; ifb.iINFO_COUNT = 7'd0; ifb.iCLEAR = 1'b0;
        ifb.iIRQ_ACK = 1'b0; ifb.iRD_REQ = 1'b0; ifb.iRD_SEL = 2'd0;

        test_reset();
        test_warmup();
        test_samples();
        test_irq_set_wins();
        test_clear();
        test_lone_ack_and_resume();
        test_back_to_back();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
